// File: rtl/chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and counter sizing.
package chunk_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A single-chunk configuration still needs a 1-bit counter to keep the select legal.
   function automatic int cnt_width(input int width, input int chunk);
      int n;
      n = width / chunk;
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/chunk_add_cell.sv
// Combinational CHUNK-bit adder slice; with CHUNK=1 it reduces to a full adder.
// Exposes the carry into its MSB when CHUNK_ADDER_OVF_EN is defined.
module chunk_add_cell #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] out,
   output logic             cout
`ifdef CHUNK_ADDER_OVF_EN
   ,
   output logic             cmsb
`endif
);

   logic [CHUNK:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign out  = full[CHUNK-1:0];
   assign cout = full[CHUNK];

`ifdef CHUNK_ADDER_OVF_EN
   // The MSB result bit is a^b^carry_in, so the carry into it can be recovered directly.
   assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ out[CHUNK-1];
`endif

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock, LSB chunk first.
// Define CHUNK_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module chunk_adder
   import chunk_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CHUNK_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            NCHUNK = WIDTH / CHUNK;
   localparam int            CW     = cnt_width(WIDTH, CHUNK);
   localparam logic [CW-1:0] LAST   = CW'(NCHUNK - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] wrk_q, wrk_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic [CHUNK-1:0] a_chunk, b_chunk, cell_out;
   logic             cell_cout;
   int               idx;
   logic             accept, last, finish;

   assign idx     = int'(cnt_q) * CHUNK;
   assign a_chunk = a_q[idx +: CHUNK];
   assign b_chunk = b_q[idx +: CHUNK];
   assign last    = (cnt_q == LAST);
   assign accept  = (state_q == ST_IDLE) && in_valid;
   assign finish  = (state_q == ST_RUN) && last;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

`ifdef CHUNK_ADDER_OVF_EN
   logic cell_cmsb;
   logic ovf_q;

   chunk_add_cell #(.CHUNK(CHUNK)) u_cell (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_q),
      .out  (cell_out),
      .cout (cell_cout),
      .cmsb (cell_cmsb)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ovf_q <= 1'b0;
      end else if (finish) begin
         ovf_q <= cell_cmsb ^ cell_cout;
      end
   end

   assign ovf = ovf_q;
`else
   chunk_add_cell #(.CHUNK(CHUNK)) u_cell (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_q),
      .out  (cell_out),
      .cout (cell_cout)
   );
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         wrk_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         wrk_q   <= wrk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      wrk_d   = wrk_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               // Subtraction runs as a + ~b + !cin.
               carry_d = cin ^ sub;
            end
         end
         ST_RUN: begin
            wrk_d[idx +: CHUNK] = cell_out;
            carry_d             = cell_cout;
            if (last) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The result register is loaded with the fully merged word, never a partial one.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         if (accept) begin
            a_q <= a;
            b_q <= b ^ {WIDTH{sub}};
         end
         if (finish) begin
            sum_q  <= wrk_d;
            cout_q <= cell_cout;
         end
      end
   end

endmodule

// File: tb/tb_chunk_adder.sv
// Directed bench for chunk_adder: 16/4 configuration plus a 1-bit full-adder instance.
module tb_chunk_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv, ir, ov, ordy, ci, sb, co;
   logic [15:0] av, bv, sm;
   logic        iv1, ir1, ov1, ordy1, c1, co1;
   logic [0:0]  a1, b1, sm1;
`ifdef CHUNK_ADDER_OVF_EN
   logic        of, of1;
`endif

   chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (av),
      .b         (bv),
      .cin       (ci),
      .sub       (sb),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (sm),
      .cout      (co)
`ifdef CHUNK_ADDER_OVF_EN
      ,
      .ovf       (of)
`endif
   );

   chunk_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .in_valid  (iv1),
      .in_ready  (ir1),
      .a         (a1),
      .b         (b1),
      .cin       (c1),
      .sub       (1'b0),
      .out_valid (ov1),
      .out_ready (ordy1),
      .sum       (sm1),
      .cout      (co1)
`ifdef CHUNK_ADDER_OVF_EN
      ,
      .ovf       (of1)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
      av = x; bv = y; ci = c; sb = s; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0; av = 16'hDEAD; bv = 16'hBEEF; ci = ~c; sb = ~s;
   endtask

   task automatic wait_result(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!ov && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
   endtask

   task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic s, input logic [15:0] es,
                       input logic ec, input logic eo);
      issue(x, y, c, s);
      wait_result(tag, 4);
      check({tag, "_sum"}, sm, es);
      check({tag, "_cout"}, co, ec);
`ifdef CHUNK_ADDER_OVF_EN
      check({tag, "_ovf"}, of, eo);
`else
      if (eo) $display("note: %s overflow expected but port absent", tag);
`endif
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      check({tag, "_in_ready_after"}, ir, 1);
      check({tag, "_out_valid_after"}, ov, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; iv = 0; ordy = 0; ci = 0; sb = 0; av = 0; bv = 0;
      iv1 = 0; ordy1 = 0; a1 = 0; b1 = 0; c1 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", ir, 1);
      check("rst_out_valid", ov, 0);
      check("rst_sum", sm, 0);
      check("rst_cout", co, 0);
      check("rst1_in_ready", ir1, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      op16("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      op16("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op16("sub_cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
`ifdef CHUNK_ADDER_OVF_EN
      op16("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      op16("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

      // Backpressure with an ignored in_valid pulse while DONE
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
      wait_result("bp", 4);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", ov, 1);
         check("bp_sum", sm, 16'h0100);
         check("bp_in_ready", ir, 0);
         if (i == 2) begin
            av = 16'h0001; bv = 16'h0001; ci = 0; sb = 0; iv = 1'b1;
         end else begin
            iv = 1'b0;
         end
         @(posedge clk); #1;
      end
      iv = 1'b0;
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      check("bp_consumed_out_valid", ov, 0);
      check("bp_consumed_in_ready", ir, 1);
      check("bp_sum_kept", sm, 16'h0100);
      repeat (6) @(posedge clk);
      #1;
      check("bp_no_spurious_op", ov, 0);

      // Reset after two RUN chunks
      issue(16'h1234, 16'h1111, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", ov, 0);
      check("midrst_sum", sm, 0);
      check("midrst_in_ready", ir, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      op16("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

      // 1-bit instance against the full-adder truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         int n;
         v = i[2:0];
         a1 = v[2]; b1 = v[1]; c1 = v[0]; iv1 = 1'b1;
         @(posedge clk); #1;
         iv1 = 1'b0;
         n = 0;
         while (!ov1 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         check("fa_latency", n, 1);
         check("fa_sum", sm1, v[2] ^ v[1] ^ v[0]);
         check("fa_cout", co1, (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
         ordy1 = 1'b1;
         @(posedge clk); #1;
         ordy1 = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/chunk_adder.md
# chunk_adder

Parametrised multi-cycle adder/subtractor: a WIDTH-bit operand pair is summed CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks. Operands arrive and results leave over valid/ready handshakes. It is the sequential, width-generic successor of the team's 1-bit full adder (a, b, cin -> out, cout). It is used wherever a wide add does not fit in one cycle's timing budget.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle; 1 <= CHUNK <= WIDTH.
- sys_clk  in  1  sole clock, rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out; for sub, 1 = no borrow.
- ovf  out  1  signed overflow; port exists only with CHUNK_ADDER_OVF_EN.

## Operation
- NCHUNK = WIDTH/CHUNK. Chunk counter width = max(1, clog2(NCHUNK)).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b^{WIDTH{sub}}, carry = cin^sub, and sub; clear the counter; go to RUN.
- RUN: one chunk per cycle.
  - Working chunk i = A[i] + B'[i] + carry.
  - Write the CHUNK-bit result into the working register; update the carry.
  - After chunk NCHUNK-1: copy the working register to sum, copy the final carry to cout (ovf as well), and go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- Subtraction identity: a-b-cin = a + ~b + !cin. For sub, cout=0 means a borrow occurred.
- in_valid is ignored outside IDLE. Operand changes after acceptance have no effect.
- sum/cout change only on the RUN->DONE transition and otherwise keep their last value. Partial chunk results never appear on sum.

## Timing
- Reset values:
  - State IDLE, in_ready=1.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - Working register, carry and counter = 0.
- Latency: acceptance at edge E0 gives out_valid=1 after edge E_NCHUNK (NCHUNK cycles).
- Output handshake completes at the first edge where out_valid && out_ready. in_ready rises after that edge.
- Minimum issue period: NCHUNK+2 cycles. Input and output handshakes never coincide in the same cycle.
- NCHUNK=1: RUN lasts exactly one cycle; the flow is otherwise identical.
- Carry ripples across chunk boundaries through the register only. There is no combinational path from a, b or cin to sum.
- in_ready and out_valid are decoded from the state register only. There is no combinational dependence on in_valid or out_ready.
- Reset mid-RUN or mid-DONE: the operation is aborted and the result discarded. All outputs go to reset values. The block accepts normally after reset release.

## Configuration
- CHUNK_ADDER_OVF_EN defined:
  - ovf port present.
  - ovf = carry into the MSB XOR carry out of the MSB, evaluated on the last chunk.
  - Registered with sum and held in DONE.
- Undefined: no ovf port or logic. sum and cout are unchanged.

## Structure
- Shared package chunk_adder_pkg holds:
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE.
  - A function computing counter width from WIDTH/CHUNK.
- Sub-module chunk_add_cell: combinational CHUNK-bit adder with ports a, b, cin -> out, cout, plus MSB carry-in for ovf. With CHUNK=1 it is the 1-bit full adder.
- Top: FSM, operand/working registers, carry register, chunk mux, output registers.

## Test plan
- WIDTH=16, CHUNK=4: a=0x1234, b=0x1111, cin=0, sub=0 -> sum=0x2345, cout=0; out_valid exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all 4 chunks); ovf=0.
- sub=1: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, cin=1 -> sum=0x0001, cout=1.
- With CHUNK_ADDER_OVF_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Backpressure: out_ready=0 for 5 cycles -> out_valid and sum held and in_ready=0; a new in_valid pulse is ignored; result consumed on the out_ready edge, in_ready=1 next cycle.
- Reset asserted after 2 RUN chunks -> out_valid=0, sum=0 immediately; after release, a fresh op 0x0001+0x0001 -> 0x0002. Also WIDTH=1, CHUNK=1: all 8 a/b/cin combinations match the full-adder truth table.
